// File: rtl/pe_systolic.sv
// Registered systolic-array PE: stationary weight, streamed activation,
// weight-stationary pass-through sum or output-stationary local accumulation.
module pe_systolic #(
    parameter int WIDTH    = 8,
    parameter int FRAC_BIT = 0,
    parameter bit SAT_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             b_load,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] b_out,
    input  logic             a_valid_in,
    input  logic [WIDTH-1:0] a_in,
    output logic             a_valid_out,
    output logic [WIDTH-1:0] a_out,
    input  logic [WIDTH-1:0] y_in,
    input  logic             drain,
    output logic [WIDTH-1:0] y_out,
    output logic             ovf
);

    localparam int WW = 2 * WIDTH + 1;

    localparam logic signed [WW-1:0] MAX_W =
        {{(WW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [WW-1:0] MIN_W =
        {{(WW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_N = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_N = {1'b1, {(WIDTH - 1){1'b0}}};

    logic [WIDTH-1:0] w_q, w_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             av_q, av_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             ovf_q, ovf_d;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;
    logic        [WIDTH-1:0]   base;
    logic signed [WW-1:0]      sum;
    logic                      oor;
    logic        [WIDTH-1:0]   red;

    // Product uses the weight held before this edge, even while reloading.
    assign prod    = $signed(a_in) * $signed(w_q);
    assign shifted = prod >>> FRAC_BIT;
    assign base    = mode ? acc_q : y_in;
    assign sum     = $signed({{(WW - WIDTH){base[WIDTH-1]}}, base})
                   + $signed({shifted[2*WIDTH-1], shifted});
    assign oor     = (sum > MAX_W) || (sum < MIN_W);

    always_comb begin
        red = sum[WIDTH-1:0];
        if (SAT_EN && oor) begin
            red = sum[WW-1] ? MIN_N : MAX_N;
        end
    end

    always_comb begin
        w_d   = w_q;
        acc_d = acc_q;
        a_d   = a_q;
        av_d  = a_valid_in;
        y_d   = y_q;
        ovf_d = ovf_q;
        if (b_load) begin
            w_d = b_in;
        end
        if (a_valid_in) begin
            a_d = a_in;
        end
        if (!mode) begin
            if (a_valid_in) begin
                y_d   = red;
                ovf_d = ovf_q | oor;
            end
        end else if (drain) begin
            y_d   = acc_q;
            acc_d = y_in;
        end else if (a_valid_in) begin
            acc_d = red;
            ovf_d = ovf_q | oor;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q   <= '0;
            acc_q <= '0;
            a_q   <= '0;
            av_q  <= 1'b0;
            y_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            w_q   <= w_d;
            acc_q <= acc_d;
            a_q   <= a_d;
            av_q  <= av_d;
            y_q   <= y_d;
            ovf_q <= ovf_d;
        end
    end

    assign b_out       = w_q;
    assign a_out       = a_q;
    assign a_valid_out = av_q;
    assign y_out       = y_q;
    assign ovf         = ovf_q;

endmodule
